// File: rtl/ti_calc_stack.sv
// Keystroke calculator: left-to-right signed integer evaluation with multi-digit
// entry, optional multiply, and a parenthesis stack of DEPTH {acc, pend} pairs.
//
// state   | meaning
// S_START | awaiting an operand (after CLEAR, reset or LP)
// S_NUM   | entering digits into entry
// S_OP    | operator pressed, pend holds it
// S_VAL   | value of a just-closed parenthesis held in acc
// S_RES   | result of EQUALS shown
// S_ERR   | error latched until CLEAR
module ti_calc_stack #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter bit EN_MULT = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [3:0]                   key_op,
  input  logic [3:0]                   key_num,
  output logic signed [WIDTH-1:0]      display,
  output logic                         error,
  output logic [$clog2(DEPTH+1)-1:0]   depth
);

  localparam int SPW = $clog2(DEPTH+1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int W2  = 2 * WIDTH;
  localparam logic [SPW-1:0] SP_MAX = SPW'(DEPTH);
  localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [W2-1:0] TEN = W2'(10);

  localparam logic [3:0] K_NONE = 4'd0, K_NUMBER = 4'd1, K_PLUS = 4'd2, K_MINUS = 4'd3,
                         K_NEGATE = 4'd4, K_EQUALS = 4'd5, K_CLEAR = 4'd6, K_LP = 4'd7,
                         K_RP = 4'd8, K_TIMES = 4'd9;

  typedef enum logic [2:0] {S_START, S_NUM, S_OP, S_VAL, S_RES, S_ERR} state_t;
  typedef enum logic [1:0] {P_NONE, P_PLUS, P_MINUS, P_TIMES} pend_t;

  function automatic logic signed [W2-1:0] widen(input logic signed [WIDTH-1:0] x);
    return {{WIDTH{x[WIDTH-1]}}, x};
  endfunction

  // A wide result is representable when its top WIDTH+1 bits are all sign copies.
  function automatic logic fits(input logic signed [W2-1:0] x);
    return (x[W2-1:WIDTH-1] == '0) || (x[W2-1:WIDTH-1] == '1);
  endfunction

  function automatic logic signed [W2-1:0] apply(input logic signed [WIDTH-1:0] a,
                                                 input pend_t p,
                                                 input logic signed [WIDTH-1:0] v);
    logic signed [W2-1:0] aw;
    logic signed [W2-1:0] vw;
    aw = widen(a);
    vw = widen(v);
    case (p)
      P_PLUS:  return aw + vw;
      P_MINUS: return aw - vw;
      P_TIMES: return aw * vw;
      default: return vw;
    endcase
  endfunction

  function automatic pend_t op_pend(input logic [3:0] op);
    case (op)
      K_PLUS:  return P_PLUS;
      K_MINUS: return P_MINUS;
      K_TIMES: return P_TIMES;
      default: return P_NONE;
    endcase
  endfunction

  state_t                  state, nxt_state;
  pend_t                   pend, nxt_pend, push_pend;
  logic signed [WIDTH-1:0] acc, nxt_acc, entry, nxt_entry, push_acc;
  logic [SPW-1:0]          sp, nxt_sp;
  logic                    do_push, do_clr;
  logic signed [WIDTH-1:0] stk_acc [DEPTH];
  pend_t                   stk_pend [DEPTH];

  logic [IW-1:0]           top_idx, push_idx;
  logic signed [W2-1:0]    dig_in, base_w, dig_w, ap_w, v_w, rp_w;

  assign push_idx = sp[IW-1:0];
  assign top_idx  = IW'(sp - 1'b1);
  assign dig_in   = {{(W2-4){1'b0}}, key_num};
  assign depth    = sp;

  // A fresh number is treated as 0*10+d so every digit goes through one range check.
  always_comb begin
    base_w = (state == S_NUM) ? widen(entry) : '0;
    dig_w  = base_w[W2-1] ? (base_w * TEN - dig_in) : (base_w * TEN + dig_in);
    ap_w   = apply(acc, pend, entry);
    v_w    = (state == S_NUM) ? ap_w : widen(acc);
    rp_w   = apply(stk_acc[top_idx], stk_pend[top_idx], v_w[WIDTH-1:0]);
  end

  always_comb begin
    nxt_state = state;
    nxt_acc   = acc;
    nxt_pend  = pend;
    nxt_entry = entry;
    nxt_sp    = sp;
    do_push   = 1'b0;
    do_clr    = 1'b0;
    push_acc  = acc;
    push_pend = pend;
    if (key_op == K_CLEAR) begin
      do_clr    = 1'b1;
      nxt_state = S_START;
      nxt_acc   = '0;
      nxt_pend  = P_NONE;
      nxt_entry = '0;
      nxt_sp    = '0;
    end else if (state != S_ERR) begin
      case (key_op)
        K_NONE: ;
        K_NUMBER: begin
          if (key_num > 4'd9 || state == S_VAL || !fits(dig_w)) begin
            nxt_state = S_ERR;
          end else begin
            nxt_entry = dig_w[WIDTH-1:0];
            nxt_state = S_NUM;
            if (state == S_RES) begin
              nxt_acc  = '0;
              nxt_pend = P_NONE;
            end
          end
        end
        K_NEGATE: begin
          case (state)
            S_NUM: begin
              if (entry == MOST_NEG) nxt_state = S_ERR;
              else nxt_entry = -entry;
            end
            S_VAL, S_RES: begin
              if (acc == MOST_NEG) nxt_state = S_ERR;
              else nxt_acc = -acc;
            end
            default: ;
          endcase
        end
        K_PLUS, K_MINUS, K_TIMES: begin
          if ((key_op == K_TIMES && !EN_MULT) || (state == S_NUM && !fits(ap_w))) begin
            nxt_state = S_ERR;
          end else begin
            if (state == S_NUM) nxt_acc = ap_w[WIDTH-1:0];
            else if (state == S_START) nxt_acc = '0;
            nxt_pend  = op_pend(key_op);
            nxt_state = S_OP;
          end
        end
        K_LP: begin
          if (state == S_NUM || state == S_VAL || sp == SP_MAX) begin
            nxt_state = S_ERR;
          end else begin
            do_push = 1'b1;
            if (state == S_RES) begin
              push_acc  = '0;
              push_pend = P_NONE;
            end
            nxt_sp    = sp + 1'b1;
            nxt_acc   = '0;
            nxt_pend  = P_NONE;
            nxt_state = S_START;
          end
        end
        K_RP: begin
          if (sp == '0 || !(state == S_NUM || state == S_VAL) || !fits(v_w) || !fits(rp_w)) begin
            nxt_state = S_ERR;
          end else begin
            nxt_sp    = sp - 1'b1;
            nxt_acc   = rp_w[WIDTH-1:0];
            nxt_pend  = P_NONE;
            nxt_state = S_VAL;
          end
        end
        K_EQUALS: begin
          if (state == S_RES) begin
            nxt_state = S_RES;
          end else if (sp != '0 || (state == S_NUM && !fits(ap_w))) begin
            nxt_state = S_ERR;
          end else begin
            if (state == S_NUM) nxt_acc = ap_w[WIDTH-1:0];
            nxt_pend  = P_NONE;
            nxt_state = S_RES;
          end
        end
        default: nxt_state = S_ERR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_START;
      acc     <= '0;
      pend    <= P_NONE;
      entry   <= '0;
      sp      <= '0;
      display <= '0;
      error   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stk_acc[i]  <= '0;
        stk_pend[i] <= P_NONE;
      end
    end else begin
      state   <= nxt_state;
      acc     <= nxt_acc;
      pend    <= nxt_pend;
      entry   <= nxt_entry;
      sp      <= nxt_sp;
      display <= (nxt_state == S_NUM) ? nxt_entry : (nxt_state == S_ERR) ? '0 : nxt_acc;
      error   <= (nxt_state == S_ERR);
      if (do_clr) begin
        for (int i = 0; i < DEPTH; i++) begin
          stk_acc[i]  <= '0;
          stk_pend[i] <= P_NONE;
        end
      end else if (do_push) begin
        stk_acc[push_idx]  <= push_acc;
        stk_pend[push_idx] <= push_pend;
      end
    end
  end

endmodule

// File: doc/ti_calc_stack.md
# ti_calc_stack

Parametrised successor to the single-level `tiCalc` keystroke calculator. It consumes one keystroke per clock and evaluates signed integer expressions left to right, with no operator precedence. New capabilities:
- multi-digit number entry;
- an optional multiply operator;
- nested parentheses up to `DEPTH` levels, held on an internal stack;
- overflow and syntax error detection.

It sits between the keypad decoder and the display driver.

## Interface
- `WIDTH`, default 8: signed datapath and display width in bits, minimum 4.
- `DEPTH`, default 4: maximum number of open parentheses, minimum 1.
- `EN_MULT`, default 1: 1 enables `TIMES`; 0 makes `TIMES` an error key.
- `clk`, in, 1 bit: clock. All state changes on its rising edge.
- `rst`, in, 1 bit: reset, asynchronous and active-high.
- `key_op`, in, 4 bits: operation code. NONE=0, NUMBER=1, PLUS=2, MINUS=3, NEGATE=4, EQUALS=5, CLEAR=6, LP=7, RP=8, TIMES=9. Codes 10–15 are errors.
- `key_num`, in, 4 bits: decimal digit. Meaningful only with NUMBER; digit values above 9 are errors.
- `display`, out, `WIDTH` bits: signed value shown.
- `error`, out, 1 bit: error flag.
- `depth`, out, `$clog2(DEPTH+1)` bits: current parenthesis nesting level.

## Operation
- **Registers:**
  - `acc`: accumulator.
  - `pend`: pending operator, one of NONE, PLUS, MINUS or TIMES.
  - `entry`: the number being entered.
  - `sp`: stack pointer.
  - Stack of `DEPTH` entries, each a pair {`acc`, `pend`}.
- **apply(a, p, v):** returns v if p=NONE, a+v if PLUS, a−v if MINUS, a·v if TIMES.
  - The computation uses 2·`WIDTH` bits.
  - A result outside the signed `WIDTH` range goes to ERR.
- **States:** START (awaiting operand), NUM (entering digits), OP (operator pressed), VAL (closed parenthesis value), RES (result shown), ERR.
- **NONE:** no change in any state.
- **CLEAR:** from any state, go to START. Zero all registers and the stack; `error` returns to 0.
- **NUMBER d:**
  - START, OP: `entry`=d, go to NUM.
  - RES: additionally set `acc`=0 and `pend`=NONE (starts a new expression).
  - NUM: `entry`=`entry`·10+d, or `entry`·10−d if `entry` is negative. Overflow goes to ERR.
  - VAL: go to ERR.
- **NEGATE:**
  - NUM: negate `entry`.
  - VAL, RES: negate `acc`.
  - START, OP: ignored.
  - Negating the most negative value goes to ERR.
- **PLUS / MINUS / TIMES:**
  - NUM: `acc`=apply(`acc`,`pend`,`entry`).
  - START: `acc`=0.
  - In all states: `pend`=op, go to OP.
  - In OP the new operator replaces the pending one.
  - TIMES with `EN_MULT`=0 goes to ERR.
- **LP:**
  - START, OP, RES: push {`acc`,`pend`}, then `acc`=0, `pend`=NONE, go to START. From RES the pushed pair is {0, NONE}.
  - NUM, VAL: go to ERR.
  - `sp`=`DEPTH` goes to ERR, with no push.
- **RP:**
  - Requires `sp`>0; otherwise go to ERR.
  - NUM: v=apply(`acc`,`pend`,`entry`). VAL: v=`acc`.
  - Pop {a,p}, set `acc`=apply(a,p,v), `pend`=NONE, go to VAL.
  - START, OP: go to ERR.
- **EQUALS:**
  - Requires `sp`=0; otherwise go to ERR.
  - NUM: `acc`=apply(`acc`,`pend`,`entry`).
  - VAL, START, OP: `acc` unchanged. A pending operator is dropped.
  - In all these states: `pend`=NONE, go to RES.
  - RES: no change.
- **Error keys** (unused codes, digit > 9): go to ERR.
- **ERR:** ignores every key except CLEAR.
- **Display source by state:**
  - NUM: `entry`.
  - START, OP, VAL, RES: `acc`.
  - ERR: 0, with `error`=1.
- **Depth:** `depth`=`sp`.

## Timing
- Keystrokes are sampled on every rising `clk` edge; one key per cycle.
- Holding a non-NONE code for n cycles counts as n keystrokes.
- Latency is 1 cycle: `display`, `error` and `depth` are registered and reflect the key sampled at edge k immediately after edge k.
- All arithmetic (including the multiply and the ×10) completes combinationally within the cycle. There is no stall and no backpressure.
- **Reset:** `rst` asserted forces, asynchronously:
  - state = START;
  - `display`=0, `error`=0, `depth`=0;
  - all registers and stack entries = 0.
- Reset has priority over any key. Assertion mid-expression discards the expression.
- After `rst` deasserts, the first key is sampled on the next rising edge.

## Test plan
- **Negate and chain** (`WIDTH`=8): 8, NEG, NEG, MINUS, 4, PLUS, 2, PLUS, 2, EQUALS, NONE, CLEAR.
  - `display` sequence: 8, −8, 8, 8, 4, 4, 2, 6, 2, 8, 8, 0.
  - `error`=0 throughout.
- **Parentheses:** 8, MINUS, LP, 4, PLUS, 1, RP, MINUS, 1, EQUALS.
  - `display` sequence: 8, 8, 0, 4, 4, 1, 3, 3, 1, 2.
  - `depth` sequence: 0, 0, 1, 1, 1, 1, 0, 0, 0, 0.
- **Multi-digit and overflow** (`WIDTH`=8):
  - 1, 2, 7 → display 127.
  - Digit 0 → `error`=1, display 0.
  - Following digit 5 → no change.
  - CLEAR → `error`=0, display 0.
- **Stack limits** (`DEPTH`=4):
  - Five LP keys → `depth` 1, 2, 3, 4, then `error`=1 on the fifth.
  - After CLEAR, RP → error.
  - After CLEAR, LP, 3, EQUALS → error (`sp`=1).
- **Multiply:**
  - 6, TIMES, 7, NEG, EQUALS → −42.
  - 1, 2, TIMES, 1, 1, EQUALS → error (132 > 127).
  - With `EN_MULT`=0, TIMES → error.
- **Async reset:**
  - Assert `rst` mid-cycle after 8, MINUS, LP → `display`=0, `error`=0, `depth`=0 before the next edge.
  - After release, 5, EQUALS → 5.
